t5_lsu: RTL and testbench
=========================

# t5_lsu

Load/store unit at the memory end of the execute datapath. Consumes the registered execute-stage opcode, funct3, effective address and replicated store data, and runs single-beat data-bus cycles with a strobe/acknowledge handshake. It stalls the pipeline until each cycle completes and returns sign- or zero-extended load data. It also flags misaligned accesses to the CSR/exception logic through `xstb` and `xwre`.

## Interface
- `XLEN`, 32 — datapath width; only 32 is supported.
- `sclk`  in  1  clock; all state updates on the rising edge.
- `srst`  in  1  reset; synchronous, active-high.
- `sena`  in  1  pipeline advance enable.
- `xopc`  in  5 [6:2]  execute-stage opcode; LOAD = 5'h00, STORE = 5'h08.
- `xfn3`  in  3 [14:12]  execute-stage funct3.
- `xea`  in  32  effective address, equal to rs1 plus the immediate.
- `xdat`  in  32  store data, already lane-replicated: byte ×4, half ×2.
- `dwb_adr`  out  30 [31:2]  word address.
- `dwb_dat_o`  out  32  write data.
- `dwb_sel`  out  4  byte lane selects.
- `dwb_we`  out  1  write enable.
- `dwb_stb`  out  1  cycle request.
- `dwb_ack`  in  1  completion; single-cycle pulse.
- `dwb_dat_i`  in  32  read data; valid while `dwb_ack` is high.
- `mlsu`  out  32  extended load result.
- `mstl`  out  1  stall request; upstream drives `sena` low while it is high.
- `xstb`  out  2  {mem op, misaligned}. `&xstb` marks a misaligned-access exception.
- `xwre`  out  1  1 = faulting or current access is a store.

## Operation
- Valid op: `xopc` is LOAD and `xfn3` ∈ {0, 1, 2, 4, 5}, or `xopc` is STORE and `xfn3` ∈ {0, 1, 2}. Any other funct3 under LOAD/STORE is a no-op: no bus cycle, `xstb[0]` = 0.
- Size is `xfn3[13:12]`: 0 = byte, 1 = half, 2 = word. `xfn3[14]` = 1 selects zero-extension.
- Misaligned: a half access with `xea[0]` = 1, or a word access with `xea[1:0]` ≠ 0. A misaligned op never starts a bus cycle.
- Lane selects:
  - byte: 4'b0001 << `xea[1:0]`
  - half: `xea[1]` ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Load extract: shift `dwb_dat_i` right by 8 × `xea[1:0]`, as captured at launch. Truncate to the access size, then sign- or zero-extend to 32 bits.
- FSM has two states, IDLE and BUSY.
  - IDLE → BUSY on an edge with `sena`=1 and a valid, aligned op. At that edge, register the address, lanes, write enable and data, and set `dwb_stb`=1.
  - BUSY holds `dwb_stb` and all bus outputs stable until `dwb_ack`.
  - BUSY with `dwb_ack`=1: capture `mlsu` if the access is a load. Then:
    - if `sena`=1 and a new valid aligned op is present, relaunch and stay BUSY (back-to-back);
    - otherwise drop `dwb_stb` and return to IDLE.
- `mstl` = (state == BUSY) & !`dwb_ack`; combinational.
- `xstb` and `xwre` are registered on every `sena` edge from the current op:
  - `xstb` = {mem op, misaligned}, where mem op is valid LOAD/STORE;
  - `xwre` = 1 when the op is a STORE.
- `mlsu` holds its value until the next load completes. Stores leave it unchanged.

## Timing
- Reset values: state IDLE, `dwb_stb`/`dwb_we` = 0, `dwb_sel` = 0, `dwb_adr`/`dwb_dat_o` = 0, `mlsu` = 0, `xstb` = 0, `xwre` = 0.
- Launch edge E: `dwb_stb` is high from E+1. The minimum cycle is 1 bus clock, with `dwb_ack` at E+1 and `mlsu` valid at E+2.
- Each wait cycle without `dwb_ack` adds one stall cycle. `mstl` stays high from E+1 through the cycle before `dwb_ack`.
- `dwb_ack` while IDLE is ignored. `mlsu` is unchanged.
- `srst` mid-cycle: return to IDLE and deassert `dwb_stb` at the next edge. An `dwb_ack` in the reset cycle is ignored.
- A misaligned op raises `&xstb` one edge after its `sena` edge. No `dwb_stb` pulse occurs.
- When `sena`=0 in IDLE, no launch occurs and `xstb`/`xwre` hold their values.

## Structure
- Shared package `t5_pkg`:
  - opcode constants OPC_LOAD and OPC_STORE;
  - size encodings SZ_B, SZ_H, SZ_W;
  - the FSM state enumeration, also reused by the future fetch unit.
- One combinational sub-module, `t5_lsu_align`. It computes lanes and the misaligned flag from (`xfn3`, `xea[1:0]`), and extracts/extends load data from (`dwb_dat_i`, offset, `xfn3`).

## Test plan
- LW at 0x100 with `dwb_dat_i` = 0xDEADBEEF and `dwb_ack` after 2 waits → `dwb_adr` = 0x40, `dwb_sel` = 1111, `mstl` high for 2 cycles, `mlsu` = 0xDEADBEEF.
- LB and LBU at 0x103 with `dwb_dat_i` = 0x80xxxxxx → LB gives `mlsu` = 0xFFFFFF80, LBU gives 0x00000080, `dwb_sel` = 1000 in both cases.
- SH at 0x202 with `xdat` = 0xBEEFBEEF → `dwb_we` = 1, `dwb_sel` = 1100, `dwb_dat_o` = 0xBEEFBEEF, `mlsu` unchanged.
- LW at 0x101 → no `dwb_stb`, `xstb` = 11, `xwre` = 0. SW at 0x302 → `xstb` = 11, `xwre` = 1.
- LW followed by SW with `sena` high on the ack cycle → `dwb_stb` stays continuously high and the second cycle launches with no idle gap.
- Assert `srst` while BUSY, then `dwb_ack` arrives → `dwb_stb` = 0 at the next edge, `mlsu` = 0, `mstl` = 0.

Source files
------------

// File: rtl/t5_pkg.sv
// Shared definitions for the t5 core: opcodes, access sizes, and
// the two-state bus FSM encoding reused by the fetch unit.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } bus_req_t;

  function automatic logic is_mem(
    input logic [4:0] opc,
    input logic [2:0] fn3
  );
    logic ld;
    logic st;
    ld = (opc == OPC_LOAD) &&
         (fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st = (opc == OPC_STORE) &&
         (fn3 inside {3'd0, 3'd1, 3'd2});
    return ld | st;
  endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Lane select / misalignment decode for the request side and
// shift + sign/zero extension of returned load data.
module t5_lsu_align
  import t5_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  ea_lo,
  output logic [3:0]  sel,
  output logic        mis,
  input  logic [31:0] dat,
  input  logic [1:0]  off,
  input  logic [2:0]  lfn3,
  output logic [31:0] ext
);

  logic [31:0] sh;
  logic        sx;

  always_comb begin
    sel = 4'b0000;
    mis = 1'b0;
    case (fn3[1:0])
      SZ_B: sel = 4'b0001 << ea_lo;
      SZ_H: begin
        sel = ea_lo[1] ? 4'b1100 : 4'b0011;
        mis = ea_lo[0];
      end
      SZ_W: begin
        sel = 4'b1111;
        mis = |ea_lo;
      end
      default: sel = 4'b0000;
    endcase
  end

  // offset and size come from the launch-time capture, not live inputs
  assign sh = dat >> {off, 3'b000};

  always_comb begin
    sx  = 1'b0;
    ext = sh;
    case (lfn3[1:0])
      SZ_B: begin
        sx  = ~lfn3[2] & sh[7];
        ext = {{24{sx}}, sh[7:0]};
      end
      SZ_H: begin
        sx  = ~lfn3[2] & sh[15];
        ext = {{16{sx}}, sh[15:0]};
      end
      default: ext = sh;
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// Load/store unit: single-beat strobe/ack data bus cycles, pipeline
// stall while a cycle is outstanding, misaligned-access flagging.
module t5_lsu
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [6:2]      xopc,
  input  logic [14:12]    xfn3,
  input  logic [XLEN-1:0] xea,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:2] dwb_adr,
  output logic [XLEN-1:0] dwb_dat_o,
  output logic [3:0]      dwb_sel,
  output logic            dwb_we,
  output logic            dwb_stb,
  input  logic            dwb_ack,
  input  logic [XLEN-1:0] dwb_dat_i,
  output logic [XLEN-1:0] mlsu,
  output logic            mstl,
  output logic [1:0]      xstb,
  output logic            xwre
);

  state_t   st;
  bus_req_t req;
  logic [1:0] off;
  logic [2:0] lfn3;

  logic       memop;
  logic       mis_raw;
  logic       mis;
  logic       go;
  logic       done;
  logic       launch;
  logic [3:0] lanes;
  logic [XLEN-1:0] ext;

  t5_lsu_align u_align (
    .fn3   (xfn3),
    .ea_lo (xea[1:0]),
    .sel   (lanes),
    .mis   (mis_raw),
    .dat   (dwb_dat_i),
    .off   (off),
    .lfn3  (lfn3),
    .ext   (ext)
  );

  assign memop  = is_mem(xopc, xfn3);
  assign mis    = memop & mis_raw;
  assign go     = memop & ~mis_raw;
  assign done   = (st == ST_BUSY) & dwb_ack;
  // a completing cycle may hand straight over to the next op
  assign launch = sena & go & ((st == ST_IDLE) | dwb_ack);
  assign mstl   = (st == ST_BUSY) & ~dwb_ack;

  assign dwb_adr   = req.adr;
  assign dwb_dat_o = req.dat;
  assign dwb_sel   = req.sel;
  assign dwb_we    = req.we;

  always_ff @(posedge sclk) begin
    if (srst) begin
      st      <= ST_IDLE;
      req     <= '0;
      off     <= 2'b00;
      lfn3    <= 3'b000;
      dwb_stb <= 1'b0;
      mlsu    <= '0;
      xstb    <= 2'b00;
      xwre    <= 1'b0;
    end else begin
      if (sena) begin
        xstb <= {memop, mis};
        xwre <= (xopc == OPC_STORE);
      end
      if (done && !req.we)
        mlsu <= ext;
      if (launch) begin
        st      <= ST_BUSY;
        dwb_stb <= 1'b1;
        req.adr <= xea[XLEN-1:2];
        req.dat <= xdat;
        req.sel <= lanes;
        req.we  <= (xopc == OPC_STORE);
        off     <= xea[1:0];
        lfn3    <= xfn3;
      end else if (done) begin
        st      <= ST_IDLE;
        dwb_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_t5_lsu.sv
// Self-checking bench for t5_lsu: scoreboard of expected bus
// requests and load results, one task per scenario.
module tb_t5_lsu;
  import t5_pkg::*;

  localparam logic [4:0] OPC_NOP = 5'h0C;

  typedef struct {
    logic [29:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [31:0] mlsu;
  } exp_t;

  logic        sclk = 1'b0;
  logic        srst;
  logic        sena;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xea;
  logic [31:0] xdat;
  logic [29:0] dwb_adr;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel;
  logic        dwb_we;
  logic        dwb_stb;
  logic        dwb_ack;
  logic [31:0] dwb_dat_i;
  logic [31:0] mlsu;
  logic        mstl;
  logic [1:0]  xstb;
  logic        xwre;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] cur_mlsu = 32'h0;

  always #5 sclk = ~sclk;

  t5_lsu #(.XLEN(32)) dut (
    .sclk      (sclk),
    .srst      (srst),
    .sena      (sena),
    .xopc      (xopc),
    .xfn3      (xfn3),
    .xea       (xea),
    .xdat      (xdat),
    .dwb_adr   (dwb_adr),
    .dwb_dat_o (dwb_dat_o),
    .dwb_sel   (dwb_sel),
    .dwb_we    (dwb_we),
    .dwb_stb   (dwb_stb),
    .dwb_ack   (dwb_ack),
    .dwb_dat_i (dwb_dat_i),
    .mlsu      (mlsu),
    .mstl      (mstl),
    .xstb      (xstb),
    .xwre      (xwre)
  );

  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic drive(input logic [4:0] opc, input logic [2:0] fn3,
                       input logic [31:0] ea, input logic [31:0] wd);
    sena = 1'b1;
    xopc = opc;
    xfn3 = fn3;
    xea  = ea;
    xdat = wd;
  endtask

  task automatic idle_in();
    sena = 1'b0;
    xopc = OPC_NOP;
    xfn3 = 3'd0;
  endtask

  task automatic check_req(input string nm);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = q.pop_front();
    if (dwb_stb !== 1'b1 || dwb_adr !== e.adr || dwb_sel !== e.sel ||
        dwb_we !== e.we || (e.we && dwb_dat_o !== e.dat)) begin
      bad++;
      $display("FAIL %s req: stb=%b adr=%h sel=%b we=%b dat=%h want adr=%h sel=%b we=%b dat=%h",
               nm, dwb_stb, dwb_adr, dwb_sel, dwb_we, dwb_dat_o,
               e.adr, e.sel, e.we, e.dat);
    end
    if (!e.we) cur_mlsu = e.mlsu;
  endtask

  task automatic check_mlsu(input string nm);
    total++;
    if (mlsu !== cur_mlsu) begin
      bad++;
      $display("FAIL %s mlsu: got %h want %h", nm, mlsu, cur_mlsu);
    end
  endtask

  task automatic run_op(input string nm, input logic [4:0] opc,
                        input logic [2:0] fn3, input logic [31:0] ea,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input logic [3:0] sel,
                        input logic [31:0] exp_mlsu);
    exp_t e;
    int stalls;
    e.adr  = ea[31:2];
    e.sel  = sel;
    e.we   = (opc == OPC_STORE);
    e.dat  = wd;
    e.mlsu = exp_mlsu;
    q.push_back(e);
    drive(opc, fn3, ea, wd);
    step();
    idle_in();
    check_req(nm);
    total++;
    if (xstb !== 2'b10 || xwre !== e.we) begin
      bad++;
      $display("FAIL %s xstb: got %b/%b want 10/%b", nm, xstb, xwre, e.we);
    end
    stalls = 0;
    for (int w = 0; w < waits; w++) begin
      if (mstl === 1'b1 && dwb_stb === 1'b1 && dwb_adr === e.adr)
        stalls++;
      step();
    end
    total++;
    if (stalls != waits) begin
      bad++;
      $display("FAIL %s stall: got %0d want %0d", nm, stalls, waits);
    end
    dwb_ack   = 1'b1;
    dwb_dat_i = rd;
    #1;
    total++;
    if (mstl !== 1'b0) begin
      bad++;
      $display("FAIL %s mstl_ack: got %b want 0", nm, mstl);
    end
    step();
    dwb_ack   = 1'b0;
    dwb_dat_i = $urandom;
    total++;
    if (dwb_stb !== 1'b0) begin
      bad++;
      $display("FAIL %s stb_drop: got %b want 0", nm, dwb_stb);
    end
    check_mlsu(nm);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    idle_in();
    xea = 32'h0;
    xdat = 32'h0;
    dwb_ack = 1'b0;
    dwb_dat_i = 32'h0;
    step();
    step();
    total++;
    if (dwb_stb !== 1'b0 || dwb_we !== 1'b0 || dwb_sel !== 4'h0 ||
        dwb_adr !== 30'h0 || dwb_dat_o !== 32'h0 || mlsu !== 32'h0 ||
        xstb !== 2'b00 || xwre !== 1'b0 || mstl !== 1'b0) begin
      bad++;
      $display("FAIL reset: stb=%b we=%b sel=%b adr=%h do=%h mlsu=%h xstb=%b xwre=%b mstl=%b",
               dwb_stb, dwb_we, dwb_sel, dwb_adr, dwb_dat_o, mlsu,
               xstb, xwre, mstl);
    end
    srst = 1'b0;
    step();
  endtask

  task automatic test_loads();
    run_op("lw", OPC_LOAD, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2,
           4'b1111, 32'hDEADBEEF);
    total++;
    if (dwb_adr !== 30'h40) begin
      bad++;
      $display("FAIL lw_adr: got %h want 40", dwb_adr);
    end
    run_op("lb", OPC_LOAD, 3'd0, 32'h103, 32'h0, 32'h80123456, 0,
           4'b1000, 32'hFFFFFF80);
    run_op("lbu", OPC_LOAD, 3'd4, 32'h103, 32'h0, 32'h80654321, 1,
           4'b1000, 32'h00000080);
    run_op("lh", OPC_LOAD, 3'd1, 32'h102, 32'h0, 32'h80017777, 0,
           4'b1100, 32'hFFFF8001);
    run_op("lhu", OPC_LOAD, 3'd5, 32'h000, 32'h0, 32'h1234F00F, 1,
           4'b0011, 32'h0000F00F);
    run_op("lb1", OPC_LOAD, 3'd0, 32'h101, 32'h0, 32'h00007F00, 0,
           4'b0010, 32'h0000007F);
  endtask

  task automatic test_store();
    run_op("sh", OPC_STORE, 3'd1, 32'h202, 32'hBEEFBEEF, 32'h55555555,
           1, 4'b1100, 32'h0);
    run_op("sb", OPC_STORE, 3'd0, 32'h201, 32'hA5A5A5A5, 32'h0,
           0, 4'b0010, 32'h0);
  endtask

  task automatic test_misaligned();
    drive(OPC_LOAD, 3'd2, 32'h101, 32'h0);
    step();
    idle_in();
    total++;
    if (dwb_stb !== 1'b0 || xstb !== 2'b11 || xwre !== 1'b0) begin
      bad++;
      $display("FAIL mis_lw: stb=%b xstb=%b xwre=%b want 0/11/0",
               dwb_stb, xstb, xwre);
    end
    drive(OPC_STORE, 3'd2, 32'h302, 32'h0);
    step();
    sena = 1'b0;
    drive(OPC_LOAD, 3'd2, 32'h400, 32'h0);
    sena = 1'b0;
    total++;
    if (dwb_stb !== 1'b0 || xstb !== 2'b11 || xwre !== 1'b1) begin
      bad++;
      $display("FAIL mis_sw: stb=%b xstb=%b xwre=%b want 0/11/1",
               dwb_stb, xstb, xwre);
    end
    step();
    total++;
    if (dwb_stb !== 1'b0 || xstb !== 2'b11 || xwre !== 1'b1) begin
      bad++;
      $display("FAIL sena_hold: stb=%b xstb=%b xwre=%b want 0/11/1",
               dwb_stb, xstb, xwre);
    end
    drive(OPC_LOAD, 3'd3, 32'h400, 32'h0);
    step();
    idle_in();
    total++;
    if (dwb_stb !== 1'b0 || xstb !== 2'b00) begin
      bad++;
      $display("FAIL bad_fn3: stb=%b xstb=%b want 0/00", dwb_stb, xstb);
    end
  endtask

  task automatic test_ack_idle();
    dwb_ack = 1'b1;
    dwb_dat_i = 32'h12345678;
    step();
    dwb_ack = 1'b0;
    total++;
    if (dwb_stb !== 1'b0 || mstl !== 1'b0) begin
      bad++;
      $display("FAIL ack_idle: stb=%b mstl=%b want 0/0", dwb_stb, mstl);
    end
    check_mlsu("ack_idle");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.adr = 30'h4; e.sel = 4'hF; e.we = 1'b0;
    e.dat = 32'h0; e.mlsu = 32'hCAFEF00D;
    q.push_back(e);
    drive(OPC_LOAD, 3'd2, 32'h10, 32'h0);
    step();
    check_req("b2b_lw");
    e.adr = 30'h8; e.sel = 4'hF; e.we = 1'b1;
    e.dat = 32'h11223344; e.mlsu = 32'h0;
    q.push_back(e);
    drive(OPC_STORE, 3'd2, 32'h20, 32'h11223344);
    dwb_ack = 1'b1;
    dwb_dat_i = 32'hCAFEF00D;
    step();
    idle_in();
    dwb_ack = 1'b0;
    check_req("b2b_sw");
    check_mlsu("b2b_lw");
    dwb_ack = 1'b1;
    step();
    dwb_ack = 1'b0;
    total++;
    if (dwb_stb !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: stb=%b want 0", dwb_stb);
    end
    check_mlsu("b2b_sw");
  endtask

  task automatic test_reset_mid();
    drive(OPC_LOAD, 3'd2, 32'h40, 32'h0);
    step();
    idle_in();
    total++;
    if (dwb_stb !== 1'b1 || mstl !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_launch: stb=%b mstl=%b want 1/1",
               dwb_stb, mstl);
    end
    srst = 1'b1;
    dwb_ack = 1'b1;
    dwb_dat_i = 32'h99999999;
    step();
    dwb_ack = 1'b0;
    srst = 1'b0;
    cur_mlsu = 32'h0;
    total++;
    if (dwb_stb !== 1'b0 || mstl !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: stb=%b mstl=%b want 0/0", dwb_stb, mstl);
    end
    check_mlsu("rst_mid");
  endtask

  initial begin
    sena = 1'b0;
    srst = 1'b1;
    @(negedge sclk);
    test_reset();
    test_loads();
    test_store();
    test_misaligned();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
